// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic tile controller.
package systolic_pkg;

  typedef enum logic [2:0] {
    LOAD = 3'b001,
    MAC  = 3'b010,
    OUT  = 3'b100
  } state_e;

  // Zero or out-of-range reduction lengths fall back to a full FIFO.
  function automatic int clamp_k(input int k_len, input int depth);
    return (k_len == 0 || k_len > depth) ? depth : k_len;
  endfunction

  // A product needs k beats plus the row/column skew to drain into the far PE.
  function automatic int mac_dur(input int k, input int rows, input int cols);
    return k + rows + cols - 2;
  endfunction

endpackage

// File: rtl/systolic_skew_gen.sv
// Skewed FIFO read-enable vector: lane i reads on cycles i .. i+k-1 of MAC.
module systolic_skew_gen
  import systolic_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 5,
  parameter int KW = 5
) (
  input  logic          en,
  input  logic [CW-1:0] c,
  input  logic [KW-1:0] k,
  output logic [N-1:0]  ren
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign ren[i] = en && (int'(c) >= i) && (int'(c) < i + int'(k));
  end

endmodule

// File: rtl/systolic_tile_ctrl.sv
// Output-stationary systolic tile controller: LOAD -> MAC -> OUT -> LOAD.
// Optional perf counters under SYSTOLIC_TILE_CTRL_PERF_EN.
module systolic_tile_ctrl
  import systolic_pkg::*;
#(
  parameter  int ROWS  = 4,
  parameter  int COLS  = 4,
  parameter  int DEPTH = 16,
  localparam int KW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [KW-1:0]   k_len,
  input  logic            x_send_val,
  output logic            x_send_rdy,
  input  logic            w_send_val,
  output logic            w_send_rdy,
  output logic [ROWS-1:0] x_fifo_wen,
  output logic [ROWS-1:0] x_fifo_ren,
  output logic [COLS-1:0] w_fifo_wen,
  output logic [COLS-1:0] w_fifo_ren,
  output logic            mac_en,
  output logic            acc_clr,
  output logic            out_val,
  input  logic            out_rdy,
  output logic            busy
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_tiles,
  output logic [31:0]     perf_stall
`endif
);

  localparam int CW = $clog2(DEPTH + ROWS + COLS);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d, x_cnt_q, x_cnt_d, w_cnt_q, w_cnt_d, k_eff;
  logic [CW-1:0] c_q, c_d;
  logic          load_first_q, load_first_d;
  logic          in_load, in_mac, in_out, x_fire, w_fire, out_fire, mac_last;

  // Outputs are forced low during reset so an abort never emits acc_clr.
  assign in_load = (state_q == LOAD) && !rst;
  assign in_mac  = (state_q == MAC)  && !rst;
  assign in_out  = (state_q == OUT)  && !rst;

  // k_len is live on the first LOAD cycle, then held in k_q for the tile.
  assign k_eff = load_first_q ? KW'(clamp_k(int'(k_len), DEPTH)) : k_q;

  assign x_send_rdy = in_load && (x_cnt_q < k_eff);
  assign w_send_rdy = in_load && (w_cnt_q < k_eff);
  assign x_fire     = x_send_val && x_send_rdy;
  assign w_fire     = w_send_val && w_send_rdy;
  assign x_fifo_wen = {ROWS{x_fire}};
  assign w_fifo_wen = {COLS{w_fire}};

  assign mac_last = (c_q == CW'(mac_dur(int'(k_q), ROWS, COLS) - 1));
  assign mac_en   = in_mac;
  assign out_val  = in_out;
  assign out_fire = in_out && out_rdy;
  assign acc_clr  = out_fire;
  assign busy     = in_mac || in_out;

  systolic_skew_gen #(.N(ROWS), .CW(CW), .KW(KW)) u_x_skew (
    .en(in_mac), .c(c_q), .k(k_q), .ren(x_fifo_ren)
  );

  systolic_skew_gen #(.N(COLS), .CW(CW), .KW(KW)) u_w_skew (
    .en(in_mac), .c(c_q), .k(k_q), .ren(w_fifo_ren)
  );

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    x_cnt_d      = x_cnt_q;
    w_cnt_d      = w_cnt_q;
    c_d          = c_q;
    load_first_d = load_first_q;
    unique case (state_q)
      LOAD: begin
        k_d          = k_eff;
        load_first_d = 1'b0;
        x_cnt_d      = x_cnt_q + KW'(x_fire);
        w_cnt_d      = w_cnt_q + KW'(w_fire);
        // Look at the post-fire counts so MAC follows the final fire directly.
        if (x_cnt_d == k_eff && w_cnt_d == k_eff) begin
          state_d = MAC;
          x_cnt_d = '0;
          w_cnt_d = '0;
          c_d     = '0;
        end
      end
      MAC: begin
        if (mac_last) begin
          state_d = OUT;
          c_d     = '0;
        end else begin
          c_d = c_q + CW'(1);
        end
      end
      OUT: begin
        if (out_fire) begin
          state_d      = LOAD;
          load_first_d = 1'b1;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      k_q          <= '0;
      x_cnt_q      <= '0;
      w_cnt_q      <= '0;
      c_q          <= '0;
      load_first_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      x_cnt_q      <= x_cnt_d;
      w_cnt_q      <= w_cnt_d;
      c_q          <= c_d;
      load_first_q <= load_first_d;
    end
  end

`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  logic [31:0] perf_tiles_q, perf_tiles_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_tiles_d = perf_tiles_q;
    perf_stall_d = perf_stall_q;
    if (out_fire && !(&perf_tiles_q))            perf_tiles_d = perf_tiles_q + 32'd1;
    if (in_out && !out_rdy && !(&perf_stall_q))  perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_tiles_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_tiles_q <= perf_tiles_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_tiles = perf_tiles_q;
  assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_systolic_tile_ctrl.sv
// Randomized bench for systolic_tile_ctrl against a per-tile transaction model.
module tb_systolic_tile_ctrl;

  localparam int ROWS  = 4;
  localparam int COLS  = 4;
  localparam int DEPTH = 16;
  localparam int KW    = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [KW-1:0]   k_len = '0;
  logic            x_send_val = 1'b0, w_send_val = 1'b0, out_rdy = 1'b0;
  logic            x_send_rdy, w_send_rdy, mac_en, acc_clr, out_val, busy;
  logic [ROWS-1:0] x_fifo_wen, x_fifo_ren;
  logic [COLS-1:0] w_fifo_wen, w_fifo_ren;
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
  logic [31:0]     perf_tiles, perf_stall;
`endif

  int n_chk = 0, n_pass = 0;
  int exp_tiles = 0, exp_stall = 0;

  always #5 clk = ~clk;

  systolic_tile_ctrl #(.ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .k_len(k_len),
    .x_send_val(x_send_val), .x_send_rdy(x_send_rdy),
    .w_send_val(w_send_val), .w_send_rdy(w_send_rdy),
    .x_fifo_wen(x_fifo_wen), .x_fifo_ren(x_fifo_ren),
    .w_fifo_wen(w_fifo_wen), .w_fifo_ren(w_fifo_ren),
    .mac_en(mac_en), .acc_clr(acc_clr), .out_val(out_val),
    .out_rdy(out_rdy), .busy(busy)
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    , .perf_tiles(perf_tiles), .perf_stall(perf_stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc_chk(input string ph, input bit xr, input bit wr,
                         input logic [ROWS-1:0] xw, input logic [ROWS-1:0] xren,
                         input logic [COLS-1:0] ww, input logic [COLS-1:0] wren,
                         input bit men, input bit clr, input bit ov, input bit bsy);
    chk({ph, ".x_rdy"},  32'(x_send_rdy), 32'(xr));
    chk({ph, ".w_rdy"},  32'(w_send_rdy), 32'(wr));
    chk({ph, ".x_wen"},  32'(x_fifo_wen), 32'(xw));
    chk({ph, ".x_ren"},  32'(x_fifo_ren), 32'(xren));
    chk({ph, ".w_wen"},  32'(w_fifo_wen), 32'(ww));
    chk({ph, ".w_ren"},  32'(w_fifo_ren), 32'(wren));
    chk({ph, ".mac_en"}, 32'(mac_en),     32'(men));
    chk({ph, ".acc_clr"},32'(acc_clr),    32'(clr));
    chk({ph, ".out_val"},32'(out_val),    32'(ov));
    chk({ph, ".busy"},   32'(busy),       32'(bsy));
  endtask

  task automatic perf_chk(input string ph);
`ifdef SYSTOLIC_TILE_CTRL_PERF_EN
    chk({ph, ".perf_tiles"}, perf_tiles, 32'(exp_tiles));
    chk({ph, ".perf_stall"}, perf_stall, 32'(exp_stall));
`else
    chk({ph, ".busy_idle"}, 32'(busy), 32'd0);
`endif
  endtask

  // One tile from its first LOAD cycle through the OUT handshake.
  // abort_c >= 0 asserts rst on that MAC cycle and ends the tile there.
  task automatic run_tile(input int klen, input int w_delay, input int stall,
                          input int abort_c, input bit rnd);
    int K, nx, nw, cyc;
    bit xv, wv, xf, wf;
    logic [ROWS-1:0] exr;
    logic [COLS-1:0] ewr;
    K  = (klen == 0 || klen > DEPTH) ? DEPTH : klen;
    nx = 0; nw = 0; cyc = 0;
    do begin
      @(posedge clk); #1;
      rst   = 1'b0;
      k_len = (cyc == 0) ? KW'(klen) : KW'($urandom_range(0, (1 << KW) - 1));
      xv = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      wv = (cyc < w_delay) ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      x_send_val = xv;
      w_send_val = wv;
      out_rdy    = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (cyc == 0) perf_chk("load_entry");
      xf = xv && (nx < K);
      wf = wv && (nw < K);
      cyc_chk("load", nx < K, nw < K, {ROWS{xf}}, '0, {COLS{wf}}, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      nx += int'(xf);
      nw += int'(wf);
      cyc++;
    end while (!(nx == K && nw == K) && cyc < 400);
    chk("load_bound", 32'(cyc < 400), 32'd1);

    for (int c = 0; c < K + ROWS + COLS - 2; c++) begin
      @(posedge clk); #1;
      x_send_val = 1'($urandom_range(0, 1));
      w_send_val = 1'($urandom_range(0, 1));
      out_rdy    = 1'($urandom_range(0, 1));
      rst        = (c == abort_c);
      @(negedge clk);
      if (c == abort_c) begin
        cyc_chk("mac_rst", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        exp_tiles = 0;
        exp_stall = 0;
        return;
      end
      for (int r = 0; r < ROWS; r++) exr[r] = (c >= r) && (c < r + K);
      for (int j = 0; j < COLS; j++) ewr[j] = (c >= j) && (c < j + K);
      cyc_chk("mac", 1'b0, 1'b0, '0, exr, '0, ewr, 1'b1, 1'b0, 1'b0, 1'b1);
    end

    for (int s = 0; s <= stall; s++) begin
      @(posedge clk); #1;
      x_send_val = 1'($urandom_range(0, 1));
      w_send_val = 1'($urandom_range(0, 1));
      out_rdy    = (s == stall);
      @(negedge clk);
      cyc_chk("out", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, s == stall, 1'b1, 1'b1);
      if (s < stall) exp_stall++;
      else           exp_tiles++;
    end
  endtask

  initial begin
    repeat (2) begin
      @(posedge clk); #1;
      rst = 1'b1; x_send_val = 1'b1; w_send_val = 1'b1; out_rdy = 1'b1;
      @(negedge clk);
      cyc_chk("reset", 1'b0, 1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    run_tile(3, 0, 0, -1, 1'b0);         // vals held high, K=3
    run_tile(4, 6, 0, -1, 1'b0);         // w beats lag the x beats
    run_tile(0, 0, 1, -1, 1'b1);         // K=0 -> DEPTH
    run_tile(DEPTH + 3, 0, 0, -1, 1'b1); // K>DEPTH -> DEPTH
    run_tile(5, 0, 5, -1, 1'b1);         // 5 stall cycles in OUT
    run_tile(6, 0, 0, 2, 1'b1);          // reset on MAC c=2
    run_tile(2, 0, 0, -1, 1'b1);
    run_tile(5, 0, 2, -1, 1'b1);
    run_tile(1, 0, 0, -1, 1'b1);
    @(posedge clk); #1;
    x_send_val = 1'b0; w_send_val = 1'b0;
    @(negedge clk);
    perf_chk("after_three");
    for (int i = 0; i < 6; i++)
      run_tile(int'($urandom_range(0, 20)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), -1, 1'b1);
    @(posedge clk); #1;
    x_send_val = 1'b0; w_send_val = 1'b0;
    @(negedge clk);
    perf_chk("final");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
